// File: rtl/flot_div_mul_if.sv
// Operand/result bundle for the divider's final multiply stage.
//   master : side that drives the operands (reciprocal unit + dividend source)
//   slave  : flot_div_mul itself
//   in_valid/OP_A/exce_in     dividend, presented in the same cycle OP_B enters the reciprocal unit
//   rec_result/rec_exce       reciprocal 1/B and its exception tag, REC_LAT cycles later
//   out_valid/result          quotient A/B and its valid strobe
//   exce_out/underflow        exception and flush-to-zero flags, meaningful while out_valid=1
interface flot_div_mul_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] OP_A;
  logic             exce_in;
  logic [WIDTH-1:0] rec_result;
  logic             rec_exce;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             exce_out;
  logic             underflow;

  modport master (
    output in_valid, OP_A, exce_in, rec_result, rec_exce,
    input  out_valid, result, exce_out, underflow
  );

  modport slave (
    input  in_valid, OP_A, exce_in, rec_result, rec_exce,
    output out_valid, result, exce_out, underflow
  );
endinterface

// File: rtl/flot_div_mul.sv
// Final divider stage: result = A * (1/B), with A delayed to meet the reciprocal.
//   CLK   rising-edge clock for all state
//   nRST  synchronous active-low reset, clears every register
//   CE    clock enable, 0 freezes the whole pipe
//   bus   flot_div_mul_if.slave operand/result bundle
// Pipe: REC_LAT-deep A delay line -> M1 unpack -> M2 multiply -> M3 normalise/pack.
// Truncating multiply, no denormals (zero exponent field means zero).
module flot_div_mul #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned WIDTH_exp = 8,
  parameter int unsigned WIDTH_mat = 23,
  parameter int unsigned REC_LAT   = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         CE,
  flot_div_mul_if.slave bus
);

  localparam int unsigned EW   = WIDTH_exp + 2;   // exponent with sign + carry headroom
  localparam int unsigned MW   = WIDTH_mat + 1;   // mantissa incl. hidden one
  localparam int unsigned PW   = 2 * MW;          // full product width
  localparam int unsigned BIAS = (1 << (WIDTH_exp - 1)) - 1;
  localparam int unsigned EMAX = (1 << WIDTH_exp) - 1;

  // Delay line for {in_valid, OP_A, exce_in}
  logic             dly_v_q [REC_LAT];
  logic [WIDTH-1:0] dly_a_q [REC_LAT];
  logic             dly_x_q [REC_LAT];

  // M1 registers
  logic          v1_q, s1_q, z1_q, x1_q;
  logic [EW-1:0] e1_q;
  logic [MW-1:0] ma1_q, mr1_q;
  logic          v1_d, s1_d, z1_d, x1_d;
  logic [EW-1:0] e1_d;
  logic [MW-1:0] ma1_d, mr1_d;

  // M2 registers
  logic          v2_q, s2_q, z2_q, x2_q;
  logic [EW-1:0] e2_q;
  logic [PW-1:0] p2_q;
  logic [PW-1:0] p2_d;

  // Output registers
  logic             ov_q, exc_q, unf_q;
  logic [WIDTH-1:0] res_q;
  logic             ov_d, exc_d, unf_d;
  logic [WIDTH-1:0] res_d;

  // M3 intermediates
  logic                 ovf_c, unf_c;
  logic [EW-1:0]        en_c;
  logic [WIDTH_mat-1:0] mant_c;

  // Product bits below the truncation point are intentionally dropped
  logic unused_p_lo;
  assign unused_p_lo = ^p2_q[WIDTH_mat-1:0];

  // M1: unpack the delay-line tail against the reciprocal
  always_comb begin
    logic [WIDTH-1:0] a_t;
    logic [WIDTH-1:0] r_t;
    a_t   = dly_a_q[REC_LAT-1];
    r_t   = bus.rec_result;
    v1_d  = dly_v_q[REC_LAT-1];
    s1_d  = a_t[WIDTH-1] ^ r_t[WIDTH-1];
    e1_d  = {2'b00, a_t[WIDTH-2 -: WIDTH_exp]} + {2'b00, r_t[WIDTH-2 -: WIDTH_exp]} - EW'(BIAS);
    ma1_d = {1'b1, a_t[WIDTH_mat-1:0]};
    mr1_d = {1'b1, r_t[WIDTH_mat-1:0]};
    z1_d  = (a_t[WIDTH-2:0] == '0) || (r_t[WIDTH-2:0] == '0);
    x1_d  = dly_x_q[REC_LAT-1] | bus.rec_exce;
  end

  // M2: mantissa product
  always_comb begin
    p2_d = PW'(ma1_q) * PW'(mr1_q);
  end

  // M3: normalise, classify, pack; exponent MSB is the sign of the biased exponent
  always_comb begin
    res_d  = '0;
    exc_d  = 1'b0;
    unf_d  = 1'b0;
    ovf_c  = 1'b0;
    unf_c  = 1'b0;
    ov_d   = v2_q;
    en_c   = p2_q[PW-1] ? (e2_q + EW'(1)) : e2_q;
    mant_c = p2_q[PW-1] ? p2_q[PW-2 -: WIDTH_mat] : p2_q[PW-3 -: WIDTH_mat];
    if (z2_q) begin
      res_d = {s2_q, {(WIDTH-1){1'b0}}};
    end else if (!en_c[EW-1] && (en_c >= EW'(EMAX))) begin
      ovf_c = 1'b1;
      res_d = {s2_q, {WIDTH_exp{1'b1}}, {WIDTH_mat{1'b0}}};
    end else if (en_c[EW-1] || (en_c == '0)) begin
      unf_c = 1'b1;
      res_d = {s2_q, {(WIDTH-1){1'b0}}};
    end else begin
      res_d = {s2_q, en_c[WIDTH_exp-1:0], mant_c};
    end
    exc_d = v2_q & (x2_q | ovf_c);
    unf_d = v2_q & unf_c;
  end

  // All state: sync reset, CE-gated advance
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < int'(REC_LAT); i++) begin
        dly_v_q[i] <= 1'b0;
        dly_a_q[i] <= '0;
        dly_x_q[i] <= 1'b0;
      end
      v1_q  <= 1'b0;
      s1_q  <= 1'b0;
      z1_q  <= 1'b0;
      x1_q  <= 1'b0;
      e1_q  <= '0;
      ma1_q <= '0;
      mr1_q <= '0;
      v2_q  <= 1'b0;
      s2_q  <= 1'b0;
      z2_q  <= 1'b0;
      x2_q  <= 1'b0;
      e2_q  <= '0;
      p2_q  <= '0;
      ov_q  <= 1'b0;
      res_q <= '0;
      exc_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (CE) begin
      dly_v_q[0] <= bus.in_valid;
      dly_a_q[0] <= bus.OP_A;
      dly_x_q[0] <= bus.exce_in;
      for (int i = 1; i < int'(REC_LAT); i++) begin
        dly_v_q[i] <= dly_v_q[i-1];
        dly_a_q[i] <= dly_a_q[i-1];
        dly_x_q[i] <= dly_x_q[i-1];
      end
      v1_q  <= v1_d;
      s1_q  <= s1_d;
      z1_q  <= z1_d;
      x1_q  <= x1_d;
      e1_q  <= e1_d;
      ma1_q <= ma1_d;
      mr1_q <= mr1_d;
      v2_q  <= v1_q;
      s2_q  <= s1_q;
      z2_q  <= z1_q;
      x2_q  <= x1_q;
      e2_q  <= e1_q;
      p2_q  <= p2_d;
      ov_q  <= ov_d;
      res_q <= res_d;
      exc_q <= exc_d;
      unf_q <= unf_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.result    = res_q;
  assign bus.exce_out  = exc_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_flot_div_mul.sv
// Scoreboard bench for flot_div_mul: directed operands, a delay-line model of the
// reciprocal unit, and a monitor that pops expected results as out_valid strobes.
module tb_flot_div_mul;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned REC_LAT = 2;
  localparam int unsigned LAT     = REC_LAT + 3;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        exce;
    logic        unf;
    int unsigned issue;
  } exp_t;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  logic CE   = 1'b1;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  exp_t        sb[$];
  exp_t        mon_e;
  exp_t        last_e;
  bit          have_last = 1'b0;
  logic        adv_q = 1'b0;
  int unsigned ce_edges = 0;

  logic [31:0] rec_drv  = '0;
  logic        recx_drv = 1'b0;
  logic [31:0] rec_pipe  [REC_LAT];
  logic        recx_pipe [REC_LAT];

  always #5 CLK = ~CLK;

  flot_div_mul_if #(.WIDTH(WIDTH)) bus ();

  flot_div_mul #(
    .WIDTH(WIDTH), .WIDTH_exp(8), .WIDTH_mat(23), .REC_LAT(REC_LAT)
  ) dut (
    .CLK(CLK), .nRST(nRST), .CE(CE), .bus(bus)
  );

  // Reciprocal-unit stand-in: the 1/B value issued with A emerges REC_LAT CE-cycles later
  always @(posedge CLK) begin
    if (CE) begin
      rec_pipe[0]  <= rec_drv;
      recx_pipe[0] <= recx_drv;
      for (int i = 1; i < int'(REC_LAT); i++) begin
        rec_pipe[i]  <= rec_pipe[i-1];
        recx_pipe[i] <= recx_pipe[i-1];
      end
    end
  end
  assign bus.rec_result = rec_pipe[REC_LAT-1];
  assign bus.rec_exce   = recx_pipe[REC_LAT-1];

  always @(posedge CLK) begin
    adv_q <= CE && nRST;
    if (CE && nRST) ce_edges <= ce_edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: a new output appears only after an edge that advanced the pipe
  always @(negedge CLK) begin
    if (adv_q && bus.out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: got result %h with nothing expected", bus.result);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "/result"},    bus.result,            mon_e.res);
        check({mon_e.name, "/exce_out"},  32'(bus.exce_out),     32'(mon_e.exce));
        check({mon_e.name, "/underflow"}, 32'(bus.underflow),    32'(mon_e.unf));
        check({mon_e.name, "/latency"},   ce_edges - mon_e.issue, LAT);
        last_e    = mon_e;
        have_last = 1'b1;
      end
    end else if (!adv_q && have_last && bus.out_valid) begin
      check({last_e.name, "/held"}, bus.result, last_e.res);
    end
  end

  task automatic drive_op(input string nm, input logic [31:0] a, input logic [31:0] rec,
                          input bit xa, input bit xr,
                          input logic [31:0] res, input bit exce, input bit unf);
    exp_t e;
    @(negedge CLK); #1;
    bus.in_valid = 1'b1;
    bus.OP_A     = a;
    bus.exce_in  = xa;
    rec_drv      = rec;
    recx_drv     = xr;
    e.name  = nm;
    e.res   = res;
    e.exce  = exce;
    e.unf   = unf;
    e.issue = ce_edges;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK); #1;
      bus.in_valid = 1'b0;
      bus.exce_in  = 1'b0;
      recx_drv     = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d results still pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "/out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "/result"},    bus.result,         32'd0);
    check({tag, "/exce_out"},  32'(bus.exce_out),  32'd0);
    check({tag, "/underflow"}, 32'(bus.underflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.OP_A     = '0;
    bus.exce_in  = 1'b0;

    repeat (3) @(negedge CLK);
    #1;
    check_cleared("reset");
    nRST = 1'b1;
    idle(3);

    // Directed corner cases, issued back to back
    drive_op("basic",    32'h40400000, 32'h3F000000, 0, 0, 32'h3FC00000, 0, 0);
    drive_op("sign",     32'hC3E00000, 32'h3F000000, 0, 0, 32'hC3600000, 0, 0);
    drive_op("ovf",      32'h7F000000, 32'h40000000, 0, 0, 32'h7F800000, 1, 0);
    drive_op("ovf_exce", 32'h7F000000, 32'h40000000, 1, 0, 32'h7F800000, 1, 0);
    drive_op("emax_m1",  32'h7E800000, 32'h40000000, 0, 0, 32'h7F000000, 0, 0);
    drive_op("unf",      32'h00800000, 32'h3F000000, 0, 0, 32'h00000000, 0, 1);
    drive_op("emin",     32'h01000000, 32'h3F000000, 0, 0, 32'h00800000, 0, 0);
    drive_op("zero_a",   32'h00000000, 32'h3F000000, 0, 0, 32'h00000000, 0, 0);
    idle(1);
    drain();
    idle(2);

    // Eleven-operand stream with a two-cycle CE stall after s5
    drive_op("s0",  32'h3F800000, 32'h3F800000, 0, 0, 32'h3F800000, 0, 0);
    drive_op("s1",  32'h40000000, 32'h3E800000, 0, 0, 32'h3F000000, 0, 0);
    drive_op("s2",  32'h3FC00000, 32'h3FC00000, 0, 0, 32'h40100000, 0, 0);
    drive_op("s3",  32'h40400000, 32'h3EAAAAAB, 0, 0, 32'h3F800000, 0, 0);
    drive_op("s4",  32'hBF800000, 32'hBF000000, 0, 0, 32'h3F000000, 0, 0);
    drive_op("s5",  32'h41200000, 32'h3DCCCCCD, 0, 0, 32'h3F800000, 0, 0);
    CE = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    CE = 1'b1;
    drive_op("s6",  32'h40400000, 32'h3F000000, 1, 0, 32'h3FC00000, 1, 0);
    drive_op("s7",  32'h40800000, 32'h3F000000, 0, 1, 32'h40000000, 1, 0);
    drive_op("s8",  32'h3F800000, 32'h00000000, 0, 0, 32'h00000000, 0, 0);
    drive_op("s9",  32'h80000000, 32'h3F000000, 0, 0, 32'h80000000, 0, 0);
    drive_op("s10", 32'h80800000, 32'h3E800000, 0, 0, 32'h80000000, 0, 1);
    idle(1);
    drain();
    idle(2);

    // Reset with results in flight: r0/r1 emerge, the rest must vanish
    drive_op("r0", 32'h40400000, 32'h3F000000, 0, 0, 32'h3FC00000, 0, 0);
    drive_op("r1", 32'hC3E00000, 32'h3F000000, 0, 0, 32'hC3600000, 0, 0);
    drive_op("r2", 32'h3FC00000, 32'h3FC00000, 0, 0, 32'h40100000, 0, 0);
    drive_op("r3", 32'h40400000, 32'h3F000000, 1, 0, 32'h3FC00000, 1, 0);
    drive_op("r4", 32'h7F000000, 32'h40000000, 0, 0, 32'h7F800000, 1, 0);
    drive_op("r5", 32'h00800000, 32'h3F000000, 0, 0, 32'h00000000, 0, 1);
    @(negedge CLK); #1;
    bus.in_valid = 1'b0;
    nRST         = 1'b0;
    sb.delete();
    have_last    = 1'b0;
    @(negedge CLK); #1;
    check_cleared("mid_reset");
    nRST = 1'b1;
    idle(2);
    drive_op("post_rst", 32'h40400000, 32'h3F000000, 0, 0, 32'h3FC00000, 0, 0);
    idle(1);
    drain();
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
